// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32I decode stage feeding a DEPTH-entry FIFO; LOOPYV_RVM_EN enables RV32M decode
package loopyV_data_types;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
        ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;
    typedef enum logic {OPA_RS1, OPA_PC} opa_sel_t;
    typedef enum logic {OPB_RS2, OPB_IMM} opb_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_IMM, WB_PC4, WB_MEM} wb_sel_t;

    typedef struct packed {
        alu_op_t     aluControl;
        opa_sel_t    operandASelect;
        opb_sel_t    operandBSelect;
        wb_sel_t     writebackSelect;
        logic        rdWriteEn;
        logic [4:0]  rdAddr;
        logic [4:0]  rs1Addr;
        logic [4:0]  rs2Addr;
        logic [31:0] imm;
        logic        memRead;
        logic        memWrite;
        logic [2:0]  funct3;
        logic        branch;
        logic        jump;
        logic        ecall;
        logic        ebreak;
        logic        fence;
    } DEStageSignalsType;
endpackage

module decode_queue
    import loopyV_data_types::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output DEStageSignalsType out_control,
    output logic [31:0]       out_pc,
    output logic              out_illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  illegal_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    function automatic alu_op_t base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

`ifdef LOOPYV_RVM_EN
    function automatic alu_op_t mul_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction
`endif

    DEStageSignalsType dec_ctl;
    logic              dec_illegal;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;

    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec_ctl     = '0;
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (in_instr[6:2])
                5'b01100: begin // OP
                    dec_ctl.rdWriteEn = 1'b1;
                    dec_ctl.rdAddr    = in_instr[11:7];
                    dec_ctl.rs1Addr   = in_instr[19:15];
                    dec_ctl.rs2Addr   = in_instr[24:20];
                    if (f7 == 7'b0000000)
                        dec_ctl.aluControl = base_alu(f3);
                    else if (f7 == 7'b0100000 && f3 == 3'b000)
                        dec_ctl.aluControl = ALU_SUB;
                    else if (f7 == 7'b0100000 && f3 == 3'b101)
                        dec_ctl.aluControl = ALU_SRA;
`ifdef LOOPYV_RVM_EN
                    else if (f7 == 7'b0000001)
                        dec_ctl.aluControl = mul_alu(f3);
`endif
                    else
                        dec_illegal = 1'b1;
                end
                5'b00100: begin // OP_IMM
                    dec_ctl.rdWriteEn      = 1'b1;
                    dec_ctl.rdAddr         = in_instr[11:7];
                    dec_ctl.rs1Addr        = in_instr[19:15];
                    dec_ctl.operandBSelect = OPB_IMM;
                    dec_ctl.imm            = imm_i;
                    dec_ctl.aluControl     = base_alu(f3);
                    if (f3 == 3'b001 || f3 == 3'b101)
                        dec_ctl.imm = {27'b0, in_instr[24:20]};
                    if (f3 == 3'b001 && f7 != 7'b0000000)
                        dec_illegal = 1'b1;
                    if (f3 == 3'b101) begin
                        if (f7 == 7'b0100000)
                            dec_ctl.aluControl = ALU_SRA;
                        else if (f7 != 7'b0000000)
                            dec_illegal = 1'b1;
                    end
                end
                5'b01101: begin // LUI
                    dec_ctl.rdWriteEn       = 1'b1;
                    dec_ctl.rdAddr          = in_instr[11:7];
                    dec_ctl.imm             = imm_u;
                    dec_ctl.writebackSelect = WB_IMM;
                end
                5'b00101: begin // AUIPC
                    dec_ctl.rdWriteEn      = 1'b1;
                    dec_ctl.rdAddr         = in_instr[11:7];
                    dec_ctl.imm            = imm_u;
                    dec_ctl.operandASelect = OPA_PC;
                    dec_ctl.operandBSelect = OPB_IMM;
                end
                5'b11011: begin // JAL
                    dec_ctl.rdWriteEn       = 1'b1;
                    dec_ctl.rdAddr          = in_instr[11:7];
                    dec_ctl.imm             = imm_j;
                    dec_ctl.jump            = 1'b1;
                    dec_ctl.operandASelect  = OPA_PC;
                    dec_ctl.operandBSelect  = OPB_IMM;
                    dec_ctl.writebackSelect = WB_PC4;
                end
                5'b11001: begin // JALR
                    dec_ctl.rdWriteEn       = 1'b1;
                    dec_ctl.rdAddr          = in_instr[11:7];
                    dec_ctl.rs1Addr         = in_instr[19:15];
                    dec_ctl.imm             = imm_i;
                    dec_ctl.jump            = 1'b1;
                    dec_ctl.operandBSelect  = OPB_IMM;
                    dec_ctl.writebackSelect = WB_PC4;
                    dec_illegal             = (f3 != 3'b000);
                end
                5'b11000: begin // BRANCH
                    dec_ctl.rs1Addr    = in_instr[19:15];
                    dec_ctl.rs2Addr    = in_instr[24:20];
                    dec_ctl.imm        = imm_b;
                    dec_ctl.branch     = 1'b1;
                    dec_ctl.funct3     = f3;
                    dec_ctl.aluControl = ALU_SUB;
                    dec_illegal        = (f3 == 3'b010 || f3 == 3'b011);
                end
                5'b00000: begin // LOAD
                    dec_ctl.rdWriteEn       = 1'b1;
                    dec_ctl.rdAddr          = in_instr[11:7];
                    dec_ctl.rs1Addr         = in_instr[19:15];
                    dec_ctl.imm             = imm_i;
                    dec_ctl.memRead         = 1'b1;
                    dec_ctl.funct3          = f3;
                    dec_ctl.operandBSelect  = OPB_IMM;
                    dec_ctl.writebackSelect = WB_MEM;
                    dec_illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                                    f3 == 3'b100 || f3 == 3'b101);
                end
                5'b01000: begin // STORE
                    dec_ctl.rs1Addr        = in_instr[19:15];
                    dec_ctl.rs2Addr        = in_instr[24:20];
                    dec_ctl.imm            = imm_s;
                    dec_ctl.memWrite       = 1'b1;
                    dec_ctl.funct3         = f3;
                    dec_ctl.operandBSelect = OPB_IMM;
                    dec_illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
                end
                5'b00011: begin // MISC_MEM
                    dec_ctl.fence = 1'b1;
                    dec_illegal   = (f3 != 3'b000);
                end
                5'b11100: begin // SYSTEM
                    if (f3 == 3'b000 && in_instr[31:20] == 12'd0)
                        dec_ctl.ecall = 1'b1;
                    else if (f3 == 3'b000 && in_instr[31:20] == 12'd1)
                        dec_ctl.ebreak = 1'b1;
                    else
                        dec_illegal = 1'b1;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
        // Illegal entries carry no side effects downstream
        if (dec_illegal)
            dec_ctl = '0;
    end

    DEStageSignalsType mem_ctl [DEPTH];
    logic [31:0]       mem_pc  [DEPTH];
    logic              mem_ill [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, push, pop;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = !full && !halted && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign out_control = out_valid ? mem_ctl[rd_ptr] : '0;
    assign out_pc      = out_valid ? mem_pc[rd_ptr]  : '0;
    assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ctl[wr_ptr] <= dec_ctl;
            mem_pc[wr_ptr]  <= in_pc;
            mem_ill[wr_ptr] <= dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            halted      <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && dec_illegal) begin
                halted <= 1'b1;
                if (illegal_cnt != '1)
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue
module tb_decode_queue;
    import loopyV_data_types::*;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic              out_illegal, halted;
    logic [31:0]       in_instr, in_pc, out_pc;
    logic [15:0]       illegal_cnt;
    DEStageSignalsType out_control;

    decode_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
        .out_pc(out_pc), .out_illegal(out_illegal), .halted(halted), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        DEStageSignalsType ctl;
        logic [31:0]       pc;
        logic              ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %0h expected none", out_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_illegal", out_illegal, e.ill);
                if (e.ill)
                    chk("pop_ill_rdwe", out_control.rdWriteEn, 1'b0);
                else
                    chk("pop_ctl", out_control, e.ctl);
            end
        end
    end

    task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                        input DEStageSignalsType ctl, input logic ill);
        exp_t e;
        int t = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 (pc %0h)", pc);
        end else begin
            e.ctl = ctl;
            e.pc  = pc;
            e.ill = ill;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", {31'd0, out_valid, 32'(sb.size())}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    DEStageSignalsType e;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cnt", illegal_cnt, 16'd0);
        chk("rst_ctl", out_control, '0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_illegal", out_illegal, 1'b0);
        @(posedge clk); #1;

        // addi x1,x0,5 with one-cycle latency
        out_ready = 1'b1;
        e = '0; e.aluControl = ALU_ADD; e.operandBSelect = OPB_IMM;
        e.rdWriteEn = 1'b1; e.rdAddr = 5'd1; e.imm = 32'h5;
        push(32'h0050_0093, 32'h0, e, 1'b0);
        @(negedge clk);
        chk("latency_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        drain();

        // Fill to full with out_ready low
        out_ready = 1'b0;
        e = '0; e.rdWriteEn = 1'b1; e.rdAddr = 5'd3; e.rs1Addr = 5'd1; e.rs2Addr = 5'd2;
        push(32'h0020_81B3, 32'h4, e, 1'b0);
        e = '0; e.aluControl = ALU_SUB; e.rdWriteEn = 1'b1; e.rdAddr = 5'd4;
        e.rs1Addr = 5'd3; e.rs2Addr = 5'd1;
        push(32'h4011_8233, 32'h8, e, 1'b0);
        e = '0; e.rdWriteEn = 1'b1; e.rdAddr = 5'd5; e.imm = 32'h1234_5000;
        e.writebackSelect = WB_IMM;
        push(32'h1234_52B7, 32'hC, e, 1'b0);
        e = '0; e.memWrite = 1'b1; e.funct3 = 3'd2; e.rs1Addr = 5'd1; e.rs2Addr = 5'd2;
        e.imm = 32'h8; e.operandBSelect = OPB_IMM;
        push(32'h0020_A423, 32'h10, e, 1'b0);
        in_valid = 1'b1; in_instr = 32'h0000_0863; in_pc = 32'h14;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("hold_pc0", out_pc, 32'h4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_pc1", out_pc, 32'h4);
        chk("hold_out_valid", out_valid, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("no_passthru", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_pop", in_ready, 1'b1);
        if (in_ready) begin
            exp_t x;
            x.ctl = '0; x.ctl.branch = 1'b1; x.ctl.aluControl = ALU_SUB; x.ctl.imm = 32'h10;
            x.pc = 32'h14; x.ill = 1'b0;
            sb.push_back(x);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        drain();

        // Immediate shifts
        e = '0; e.aluControl = ALU_SRA; e.operandBSelect = OPB_IMM; e.imm = 32'h2;
        e.rdWriteEn = 1'b1; e.rdAddr = 5'd1; e.rs1Addr = 5'd1;
        push(32'h4020_D093, 32'h20, e, 1'b0);
        e.aluControl = ALU_SRL;
        push(32'h0020_D093, 32'h24, e, 1'b0);
        drain();

        // Flush discards queued entries and blocks a same-cycle push
        out_ready = 1'b0;
        e = '0; e.aluControl = ALU_ADD; e.operandBSelect = OPB_IMM;
        e.rdWriteEn = 1'b1; e.rdAddr = 5'd1; e.imm = 32'h5;
        push(32'h0050_0093, 32'h40, e, 1'b0);
        push(32'h0050_0093, 32'h44, e, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h48;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        sb.delete();
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_empty", out_valid, 1'b0);
        @(posedge clk); #1;

        // Illegal instruction halts intake
        push(32'hFFFF_FFFF, 32'h50, '0, 1'b1);
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h54;
        @(negedge clk);
        chk("ill_halted", halted, 1'b1);
        chk("ill_cnt", illegal_cnt, 16'd1);
        chk("ill_head", out_illegal, 1'b1);
        chk("halt_in_ready", in_ready, 1'b0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("halt_drained", out_valid, 1'b0);
        chk("halt_stays", halted, 1'b1);
        chk("halt_in_ready2", in_ready, 1'b0);
        @(posedge clk); #1 flush = 1'b1; in_instr = 32'hFFFF_FFFF;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("unhalt", halted, 1'b0);
        chk("unhalt_valid", out_valid, 1'b0);
        chk("flush_keeps_cnt", illegal_cnt, 16'd1);
        chk("unhalt_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        push(32'h0050_0093, 32'h60, e, 1'b0);
        push(32'h0050_0093, 32'h64, e, 1'b0);
        push(32'h0050_0093, 32'h68, e, 1'b0);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_cnt", illegal_cnt, 16'd0);
        chk("arst_pc", out_pc, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // mul x0,x1,x2
        out_ready = 1'b1;
`ifdef LOOPYV_RVM_EN
        e = '0; e.aluControl = ALU_MUL; e.rdWriteEn = 1'b1; e.rs1Addr = 5'd1; e.rs2Addr = 5'd2;
        push(32'h0220_8033, 32'h70, e, 1'b0);
        drain();
        chk("mul_not_halted", halted, 1'b0);
`else
        push(32'h0220_8033, 32'h70, '0, 1'b1);
        drain();
        chk("mul_halted", halted, 1'b1);
`endif
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
